// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-line bundle for serial_pattern_tx.
// master = requester side (drives start/data_in), slave = transmitter side.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
);
  // Handshake: a word is accepted on any rising edge where start=1 and ready=1;
  // start is ignored while ready=0, and data_in matters only on the accept edge.
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             x_out;
  logic             frame;
  logic             done;

  modport master (
    output start, data_in,
    input  ready, x_out, frame, done
  );

  modport slave (
    input  start, data_in,
    output ready, x_out, frame, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// MSB-first serial frame transmitter with registered frame/done strobes.
// Optional even-parity bit after the LSB when TX_PARITY_EN is defined.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic               clock,
  input  logic               reset,
  serial_pattern_tx_if.slave bus,
  output logic [1:0]         dbg_state
);
  localparam int BW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam int GW = ($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef TX_PARITY_EN
    S_PAR   = 2'd2,
`endif
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             x_q, x_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
`ifdef TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Every output is computed one cycle ahead so it can be registered:
  // state_q always describes what the outputs are showing right now.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = 1'b0;
    frame_d   = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b0;
`ifdef TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.start) begin
          state_d   = S_SHIFT;
          x_d       = bus.data_in[WIDTH-1];
          frame_d   = 1'b1;
          ready_d   = 1'b0;
          shreg_d   = {bus.data_in[WIDTH-2:0], 1'b0};
          bit_cnt_d = BIT_LOAD;
`ifdef TX_PARITY_EN
          par_d     = ^bus.data_in;
`endif
        end
      end
      S_SHIFT: begin
        // bit_cnt_q counts data bits still to come after the one on x_out
        if (bit_cnt_q != '0) begin
          x_d       = shreg_q[WIDTH-1];
          frame_d   = 1'b1;
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - BW'(1);
`ifndef TX_PARITY_EN
          done_d    = (bit_cnt_q == BW'(1));
`endif
        end else begin
`ifdef TX_PARITY_EN
          state_d = S_PAR;
          x_d     = par_q;
          frame_d = 1'b1;
          done_d  = 1'b1;
`else
          if (GAP == 0) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
`endif
        end
      end
`ifdef TX_PARITY_EN
      S_PAR: begin
        if (GAP == 0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
`endif
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
`ifdef TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.x_out = x_q;
  assign bus.frame = frame_q;
  assign bus.done  = done_q;
  assign bus.ready = ready_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one GAP=2 instance and one GAP=0 instance.
module tb_serial_pattern_tx;
  localparam int W = 1;
`ifdef TX_PARITY_EN
  localparam int F = 9;
`else
  localparam int F = 8;
`endif

  logic clock;
  logic reset;
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;
  int vec_cnt;
  int err_cnt;
  int done_seen;
  logic [W-1:0] exp_q[$];

  serial_pattern_tx_if #(.WIDTH(8)) ifa ();
  serial_pattern_tx_if #(.WIDTH(8)) ifb ();

  serial_pattern_tx #(.WIDTH(8), .GAP(2)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .bus       (ifa.slave),
    .dbg_state (dbg_a)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP(0)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .bus       (ifb.slave),
    .dbg_state (dbg_b)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check_val({tag, "_ready"}, 32'(ifa.ready), 32'd1);
    check_val({tag, "_x"},     32'(ifa.x_out), 32'd0);
    check_val({tag, "_frame"}, 32'(ifa.frame), 32'd0);
    check_val({tag, "_done"},  32'(ifa.done),  32'd0);
  endtask

  // Sends one word on instance A; bits is the hand-written MSB-first pattern.
  task automatic frame_a(input string name, input logic [7:0] word, input string bits,
                         input logic par, input bit hazard);
    logic [W-1:0] e;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(bits[i] == "1"));
    if (F == 9) exp_q.push_back(par);
    ifa.data_in = word;
    ifa.start   = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int k = 0; k < F; k++) begin
      if (k > 0) tick();
      if (hazard && k == 3) begin
        ifa.start   = 1'b1;
        ifa.data_in = 8'hFF;
      end
      if (hazard && k == 4) ifa.start = 1'b0;
      e = exp_q.pop_front();
      check_val($sformatf("%s_bit%0d_x", name, k), 32'(ifa.x_out), 32'(e));
      check_val($sformatf("%s_bit%0d_frame", name, k), 32'(ifa.frame), 32'd1);
      check_val($sformatf("%s_bit%0d_done", name, k), 32'(ifa.done), 32'(k == F - 1));
      check_val($sformatf("%s_bit%0d_ready", name, k), 32'(ifa.ready), 32'd0);
    end
    for (int g = 0; g <= 2; g++) begin
      tick();
      check_val($sformatf("%s_gap%0d_frame", name, g), 32'(ifa.frame), 32'd0);
      check_val($sformatf("%s_gap%0d_x", name, g), 32'(ifa.x_out), 32'd0);
      check_val($sformatf("%s_gap%0d_done", name, g), 32'(ifa.done), 32'd0);
      check_val($sformatf("%s_gap%0d_ready", name, g), 32'(ifa.ready), 32'(g == 2));
    end
    tick();
    check_idle_a({name, "_after"});
  endtask

  initial begin
    vec_cnt     = 0;
    err_cnt     = 0;
    done_seen   = 0;
    reset       = 1'b0;
    ifa.start   = 1'b1;
    ifa.data_in = 8'hA5;
    ifb.start   = 1'b0;
    ifb.data_in = 8'h00;

    // reset held with start requested
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_a($sformatf("rst%0d", i));
      check_val($sformatf("rst%0d_state", i), 32'(dbg_a), 32'd0);
    end
    ifa.start = 1'b0;
    #2 reset = 1'b1;
    tick();
    check_idle_a("post_rst");

    frame_a("a5", 8'hA5, "10100101", 1'b0, 1'b0);
    frame_a("a5_hz", 8'hA5, "10100101", 1'b0, 1'b1);
    frame_a("p07", 8'h07, "00000111", 1'b1, 1'b0);

    // reset pulse in the middle of a frame
    ifa.data_in = 8'h3C;
    ifa.start   = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check_val("mid_bit4_x", 32'(ifa.x_out), 32'd1);
    check_val("mid_bit4_frame", 32'(ifa.frame), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_idle_a("async_rst");
    check_val("async_rst_state", 32'(dbg_a), 32'd0);
    tick();
    check_idle_a("rst_hold");
    #2 reset = 1'b1;
    tick();
    check_idle_a("rst_rel");
    frame_a("3c", 8'h3C, "00111100", 1'b0, 1'b0);

    // GAP=0 instance with start held high
    ifb.data_in = 8'h81;
    ifb.start   = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < F; k++) begin
        tick();
        if (ifb.done === 1'b1) done_seen++;
        check_val($sformatf("b%0d_bit%0d_x", r, k), 32'(ifb.x_out),
                  32'((k == 0 || k == 7) ? 1 : 0));
        check_val($sformatf("b%0d_bit%0d_frame", r, k), 32'(ifb.frame), 32'd1);
        check_val($sformatf("b%0d_bit%0d_done", r, k), 32'(ifb.done), 32'(k == F - 1));
      end
      tick();
      if (ifb.done === 1'b1) done_seen++;
      check_val($sformatf("b%0d_idle_frame", r), 32'(ifb.frame), 32'd0);
      check_val($sformatf("b%0d_idle_ready", r), 32'(ifb.ready), 32'd1);
    end
    ifb.start = 1'b0;
    tick();
    check_val("b_stop_frame", 32'(ifb.frame), 32'd0);
    check_val("b_done_total", 32'(done_seen), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream transmitter: accepts a WIDTH-bit word over a start/ready handshake and shifts it out MSB-first on a single-bit line, one bit per clock. It drives the `x_in` input of the serial Mealy state machines in the HW3 exercises, so the bench can feed them deterministic frames instead of hand-wiggled stimulus. A registered frame strobe and a done pulse mark the bit boundaries for the receiving FSM and for scoreboards.

## Interface

Parameters:
- `WIDTH`, default 8: data bits per frame (>= 2).
- `GAP`, default 2: idle cycles inserted after each frame before `ready` returns (>= 0).

Ports:
- `clock`  input  1: single clock; all state changes on its rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `start`  input  1: transmit request; sampled only while `ready`=1.
- `data_in`  input  WIDTH: word to send; captured on the accept edge.
- `ready`  output  1: block is idle and will accept `start`.
- `x_out`  output  1: serial data bit; MSB first.
- `frame`  output  1: high while `x_out` carries a valid frame bit.
- `done`  output  1: one-cycle pulse, coincident with the last bit of the frame.

## Operation

- All outputs registered. Reset values: `ready`=1, `x_out`=0, `frame`=0, `done`=0, state IDLE, shift register 0, counters 0.
- States: IDLE, SHIFT, PAR (parity build only), GAP.
- IDLE: `ready`=1, `frame`=0, `x_out`=0. `start`=1 at a rising edge -> capture `data_in`, load bit counter with WIDTH-1, go to SHIFT; `ready` drops on that same edge.
- SHIFT: `x_out`=current MSB of shift register, `frame`=1; register shifts left each edge, bit counter decrements. On the last data bit: without parity -> `done`=1 and next state GAP (or IDLE if GAP=0); with parity -> next state PAR.
- PAR: `x_out`=even parity of the captured word (XOR of all WIDTH bits), `frame`=1, `done`=1; next state GAP (or IDLE if GAP=0).
- GAP: `frame`=0, `x_out`=0, `ready`=0 for exactly GAP cycles, then IDLE.
- `start` outside IDLE is ignored; no queuing. Changes to `data_in` after the accept edge have no effect.
- Reset asserted mid-frame: immediate (asynchronous) return to reset values; the partial frame is discarded, no `done`.
- Counter width: $clog2(WIDTH) bits for the bit counter, $clog2(GAP+1) bits for the gap counter (min 1 bit each).

## Timing

- Accept edge = edge 0. First bit (MSB) valid after edge 0, last data bit after edge WIDTH-1; parity bit (if built) after edge WIDTH.
- `done` high for exactly one cycle, aligned with the final frame bit.
- Frame length F = WIDTH (+1 with parity). `ready` returns high after edge F+GAP.
- Minimum start-to-start period: F+GAP+1 cycles. With `start` held high and GAP=0, `frame` is low for exactly one cycle between frames.

## Configuration

- Macro `TX_PARITY_EN`.
- Defined: PAR state present; every frame is WIDTH+1 bits with an even-parity bit appended after the LSB; `done` moves to the parity bit.
- Undefined: PAR state and parity logic absent; frames are WIDTH bits; `done` on the LSB.

## Test plan

- Reset held low for 3 cycles with `start`=1 -> `ready`=1, `x_out`=0, `frame`=0, `done`=0 throughout; no frame starts until reset is released.
- WIDTH=8, GAP=2, no parity, `data_in`=8'hA5, one-cycle `start` -> `x_out`=1,0,1,0,0,1,0,1 after edges 0..7, `frame`=1 for those 8 cycles, `done`=1 only with the final 1, `ready`=0 until it rises after edge 10.
- Same setup, `start`=1 with `data_in`=8'hFF pulsed during bit 3 -> frame still 8'hA5, no second frame; `ready` behaviour unchanged.
- `TX_PARITY_EN` defined, `data_in`=8'h07 -> bits 0,0,0,0,0,1,1,1, then parity bit 1 as the 9th `frame` cycle, `done` on the 9th bit.
- Reset pulsed low during bit 4 of 8'h3C -> outputs go to reset values asynchronously, no `done`; the next `start` with 8'h3C sends all 8 bits 0,0,1,1,1,1,0,0.
- GAP=0, `start` held high, `data_in`=8'h81 -> repeated frames 1,0,0,0,0,0,0,1, with `frame` low for exactly one cycle between frames and one `done` per frame.
